// File: rtl/snn_segment_serializer.sv
// rtl/snn_segment_serializer.sv - UART-like serializer for the 7-bit SNN segment vector.
// Define SNN_SER_PARITY_EN to insert an even-parity bit between d6 and STOP.
module snn_segment_serializer #(
  parameter int pBIT_CYCLES = 120
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  input  logic [6:0] iSEGMENTS,
  input  logic       iSET,
  output logic       oSERIAL,
  output logic       oBUSY,
  output logic       oACCEPT,
  output logic       oDROP,
  output logic       oDONE
);

  localparam int cCW = $clog2(pBIT_CYCLES);
  localparam logic [cCW-1:0] cLAST = cCW'(pBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    sIDLE   = 3'd0,
    sSTART  = 3'd1,
    sDATA   = 3'd2,
`ifdef SNN_SER_PARITY_EN
    sPARITY = 3'd3,
`endif
    sSTOP   = 3'd4
  } tState;

  tState          state, stateNext;
  logic [cCW-1:0] bitCnt, bitCntNext;
  logic [2:0]     dataIdx, dataIdxNext;
  logic [6:0]     shiftReg, shiftNext;
  logic [6:0]     pendReg, pendNext;
  logic           pendValid, pendValidNext;
  logic           takeNow, dropNow, doneNow;
  logic           serialNext, busyNext;
  logic           terminal, drainEdge;

  assign terminal  = (bitCnt == cLAST);
  assign drainEdge = terminal && (state == sSTOP);

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state     <= sIDLE;
      bitCnt    <= '0;
      dataIdx   <= '0;
      shiftReg  <= '0;
      pendReg   <= '0;
      pendValid <= 1'b0;
      oSERIAL   <= 1'b1;
      oBUSY     <= 1'b0;
      oACCEPT   <= 1'b0;
      oDROP     <= 1'b0;
      oDONE     <= 1'b0;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      dataIdx   <= dataIdxNext;
      shiftReg  <= shiftNext;
      pendReg   <= pendNext;
      pendValid <= pendValidNext;
      oSERIAL   <= serialNext;
      oBUSY     <= busyNext;
      oACCEPT   <= takeNow;
      oDROP     <= dropNow;
      oDONE     <= doneNow;
    end
  end

  always_comb begin
    stateNext     = state;
    bitCntNext    = bitCnt;
    dataIdxNext   = dataIdx;
    shiftNext     = shiftReg;
    pendNext      = pendReg;
    pendValidNext = pendValid;
    takeNow       = 1'b0;
    dropNow       = 1'b0;
    doneNow       = 1'b0;
    if (state == sIDLE) begin
      bitCntNext  = '0;
      dataIdxNext = '0;
      if (iSET) begin
        shiftNext = iSEGMENTS;
        stateNext = sSTART;
        takeNow   = 1'b1;
      end
    end else begin
      bitCntNext = terminal ? '0 : bitCnt + 1'b1;
      if (terminal) begin
        case (state)
          sSTART: begin
            stateNext   = sDATA;
            dataIdxNext = '0;
          end
          sDATA: begin
            if (dataIdx == 3'd6) begin
              dataIdxNext = '0;
`ifdef SNN_SER_PARITY_EN
              stateNext   = sPARITY;
`else
              stateNext   = sSTOP;
`endif
            end else begin
              dataIdxNext = dataIdx + 3'd1;
            end
          end
`ifdef SNN_SER_PARITY_EN
          sPARITY: stateNext = sSTOP;
`endif
          sSTOP: begin
            doneNow = 1'b1;
            // Pending drains into the shift register with no idle gap; a
            // coincident iSET refills the slot on the same edge.
            if (pendValid) begin
              shiftNext = pendReg;
              stateNext = sSTART;
              if (iSET) begin
                pendNext = iSEGMENTS;
                takeNow  = 1'b1;
              end else begin
                pendValidNext = 1'b0;
              end
            end else if (iSET) begin
              shiftNext = iSEGMENTS;
              stateNext = sSTART;
              takeNow   = 1'b1;
            end else begin
              stateNext = sIDLE;
            end
          end
          default: stateNext = sIDLE;
        endcase
      end
      if (iSET && !drainEdge) begin
        if (!pendValid) begin
          pendNext      = iSEGMENTS;
          pendValidNext = 1'b1;
          takeNow       = 1'b1;
        end else begin
          dropNow = 1'b1;
        end
      end
    end
  end

  // Outputs are registered from the next state so the line moves on the capturing edge.
  always_comb begin
    serialNext = 1'b1;
    case (stateNext)
      sSTART:  serialNext = 1'b0;
      sDATA:   serialNext = shiftNext[dataIdxNext];
`ifdef SNN_SER_PARITY_EN
      sPARITY: serialNext = ^shiftNext;
`endif
      default: serialNext = 1'b1;
    endcase
    busyNext = (stateNext != sIDLE) || pendValidNext;
  end

endmodule

// File: tb/tb_snn_segment_serializer.sv
// tb/tb_snn_segment_serializer.sv - scoreboard bench for snn_segment_serializer.
module tb_snn_segment_serializer;

  localparam int BIT = 4;
`ifdef SNN_SER_PARITY_EN
  localparam int FB = 10;
`else
  localparam int FB = 9;
`endif
  localparam int FL = FB * BIT;

  typedef struct {
    logic [6:0] data;
    bit         chain;
    bit         abort;
  } exp_t;

  logic       iCLK = 1'b0;
  logic       iRESETn;
  logic [6:0] iSEGMENTS;
  logic       iSET;
  logic       oSERIAL, oBUSY, oACCEPT, oDROP, oDONE;

  int checks = 0;
  int errors = 0;
  int accCnt = 0;
  int dropCnt = 0;
  int doneCnt = 0;
  exp_t expQ[$];

  always #5 iCLK = ~iCLK;

  snn_segment_serializer #(.pBIT_CYCLES(BIT)) dut (
    .iCLK      (iCLK),
    .iRESETn   (iRESETn),
    .iSEGMENTS (iSEGMENTS),
    .iSET      (iSET),
    .oSERIAL   (oSERIAL),
    .oBUSY     (oBUSY),
    .oACCEPT   (oACCEPT),
    .oDROP     (oDROP),
    .oDONE     (oDONE)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge iCLK) begin
    if (oACCEPT) accCnt++;
    if (oDROP) dropCnt++;
    if (oDONE) doneCnt++;
  end

  task automatic pulseSet(input logic [6:0] d, input logic expAcc, input logic expDrop);
    iSEGMENTS = d;
    iSET = 1'b1;
    @(negedge iCLK);
    iSET = 1'b0;
    chk("acceptPulse", oACCEPT, expAcc);
    chk("dropPulse", oDROP, expDrop);
  endtask

  task automatic clearCounts();
    accCnt = 0;
    dropCnt = 0;
    doneCnt = 0;
  endtask

  task automatic checkCounts(input string tag, input int a, input int d, input int n);
    chk({tag, "_accepts"}, accCnt, a);
    chk({tag, "_drops"}, dropCnt, d);
    chk({tag, "_dones"}, doneCnt, n);
  endtask

  // Monitor: decodes every frame on oSERIAL and compares against the queue.
  initial begin : monitor
    bit         haveStart, chained, aborted, busyOk, stable, haveExp;
    logic       vals [FL];
    logic [6:0] got;
    exp_t       e;
    haveStart = 0;
    chained = 0;
    forever begin
      if (!haveStart) begin
        @(negedge iCLK);
        if (!(iRESETn && oSERIAL == 1'b0)) continue;
        chained = 0;
      end
      haveStart = 0;
      vals[0] = oSERIAL;
      busyOk = oBUSY;
      aborted = 0;
      for (int i = 1; i < FL; i++) begin
        @(negedge iCLK);
        if (!iRESETn) begin
          aborted = 1;
          break;
        end
        vals[i] = oSERIAL;
        if (!oBUSY) busyOk = 0;
      end
      haveExp = (expQ.size() > 0);
      chk("frameExpected", haveExp, 1);
      if (!haveExp) continue;
      e = expQ.pop_front();
      chk("gapless", chained, e.chain);
      chk("aborted", aborted, e.abort);
      if (aborted || e.abort) continue;
      stable = 1;
      for (int b = 0; b < FB; b++)
        for (int c = 1; c < BIT; c++)
          if (vals[b*BIT+c] !== vals[b*BIT]) stable = 0;
      for (int b = 0; b < 7; b++) got[b] = vals[(b+1)*BIT];
      chk("data", got, e.data);
      chk("stopBit", vals[(FB-1)*BIT], 1);
`ifdef SNN_SER_PARITY_EN
      chk("parityBit", vals[8*BIT], ^e.data);
`endif
      chk("bitStable", stable, 1);
      chk("busyInFrame", busyOk, 1);
      @(negedge iCLK);
      chk("doneTiming", oDONE, 1);
      if (iRESETn && oSERIAL == 1'b0) begin
        haveStart = 1;
        chained = 1;
      end else begin
        chk("busyAfterIdle", oBUSY, 0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    iRESETn = 1'b0;
    iSET = 1'b0;
    iSEGMENTS = '0;
    repeat (3) @(negedge iCLK);
    chk("rst_serial", oSERIAL, 1);
    chk("rst_busy", oBUSY, 0);
    chk("rst_accept", oACCEPT, 0);
    chk("rst_drop", oDROP, 0);
    chk("rst_done", oDONE, 0);
    #1 iRESETn = 1'b1;
    repeat (2) @(negedge iCLK);

    // Single frame
    clearCounts();
    expQ.push_back('{7'b1010011, 1'b0, 1'b0});
    pulseSet(7'b1010011, 1'b1, 1'b0);
    chk("startBitLatency", oSERIAL, 0);
    chk("busyAfterCapture", oBUSY, 1);
    repeat (FL + 8) @(negedge iCLK);
    checkCounts("single", 1, 0, 1);

    // Back-to-back, second capture 10 cycles after the first
    clearCounts();
    expQ.push_back('{7'h55, 1'b0, 1'b0});
    pulseSet(7'h55, 1'b1, 1'b0);
    repeat (9) @(negedge iCLK);
    expQ.push_back('{7'h2A, 1'b1, 1'b0});
    pulseSet(7'h2A, 1'b1, 1'b0);
    repeat (2 * FL + 10) @(negedge iCLK);
    checkCounts("b2b", 2, 0, 2);

    // Overflow: third request is dropped
    clearCounts();
    expQ.push_back('{7'h0F, 1'b0, 1'b0});
    pulseSet(7'h0F, 1'b1, 1'b0);
    expQ.push_back('{7'h70, 1'b1, 1'b0});
    pulseSet(7'h70, 1'b1, 1'b0);
    pulseSet(7'h11, 1'b0, 1'b1);
    repeat (2 * FL + 10) @(negedge iCLK);
    checkCounts("overflow", 2, 1, 2);

    // Pending full and iSET on the STOP terminal edge
    clearCounts();
    expQ.push_back('{7'h3C, 1'b0, 1'b0});
    pulseSet(7'h3C, 1'b1, 1'b0);
    expQ.push_back('{7'h41, 1'b1, 1'b0});
    pulseSet(7'h41, 1'b1, 1'b0);
    repeat (FL - 2) @(negedge iCLK);
    expQ.push_back('{7'h6B, 1'b1, 1'b0});
    pulseSet(7'h6B, 1'b1, 1'b0);
    chk("drainDone", oDONE, 1);
    repeat (3 * FL + 10) @(negedge iCLK);
    checkCounts("simul", 3, 0, 3);

    // Reset during d3
    clearCounts();
    expQ.push_back('{7'h33, 1'b0, 1'b1});
    pulseSet(7'h33, 1'b1, 1'b0);
    repeat (17) @(negedge iCLK);
    #2 iRESETn = 1'b0;
    #1;
    chk("asyncRstSerial", oSERIAL, 1);
    chk("asyncRstBusy", oBUSY, 0);
    repeat (2) @(negedge iCLK);
    #1 iRESETn = 1'b1;
    repeat (FL) @(negedge iCLK);
    chk("noDoneAfterAbort", doneCnt, 0);
    clearCounts();
    expQ.push_back('{7'h4C, 1'b0, 1'b0});
    pulseSet(7'h4C, 1'b1, 1'b0);
    repeat (FL + 8) @(negedge iCLK);
    checkCounts("postReset", 1, 0, 1);

`ifdef SNN_SER_PARITY_EN
    clearCounts();
    expQ.push_back('{7'b0000111, 1'b0, 1'b0});
    pulseSet(7'b0000111, 1'b1, 1'b0);
    repeat (FL - 2) @(negedge iCLK);
    chk("parityNoEarlyDone", doneCnt, 0);
    repeat (10) @(negedge iCLK);
    checkCounts("parity", 1, 0, 1);
`endif

    chk("queueDrained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
